// File: rtl/i2c_fifo_sequencer_pkg.sv
// Shared definitions for the I2C FIFO sequencer: FSM state encoding.
package i2c_fifo_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_TX_LOAD  = 3'd1,
        ST_TX_SEND  = 3'd2,
        ST_TX_POP   = 3'd3,
        ST_RX_WAIT  = 3'd4,
        ST_RX_STORE = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/i2c_fifo_sequencer.sv
// I2C FIFO sequencer: moves a counted number of bytes between the TX/RX FIFOs
// and the I2C bit engine.
// Ports:
//   i2c_core_clk_i / i2c_core_rst_i : clock, synchronous active-high reset
//   start_i, rw_i, byte_cnt_i       : transfer request (sampled in IDLE)
//   tx_empty_i, tx_data_i           : TX-FIFO status and FWFT head
//   rx_full_i                       : RX-FIFO status
//   tx_byte_ready_i, nack_i         : bit engine TX handshake / slave NACK
//   rx_byte_valid_i, rx_byte_i      : bit engine RX delivery
//   r_tx_fifo_en_o, w_rx_fifo_en_o  : FIFO pop / push pulses
//   rx_data_o                       : RX-FIFO write data
//   tx_byte_valid_o, tx_byte_o      : byte offered to the bit engine
//   busy_o, stall_o, done_o, err_o  : status
//   bytes_left_o                    : remaining byte count
module i2c_fifo_sequencer
    import i2c_fifo_sequencer_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned CNTSIZE  = 8
) (
    input  logic                i2c_core_clk_i,
    input  logic                i2c_core_rst_i,
    input  logic                start_i,
    input  logic                rw_i,
    input  logic [CNTSIZE-1:0]  byte_cnt_i,
    input  logic                tx_empty_i,
    input  logic [DATASIZE-1:0] tx_data_i,
    input  logic                rx_full_i,
    input  logic                tx_byte_ready_i,
    input  logic                rx_byte_valid_i,
    input  logic [DATASIZE-1:0] rx_byte_i,
    input  logic                nack_i,
    output logic                r_tx_fifo_en_o,
    output logic                w_rx_fifo_en_o,
    output logic [DATASIZE-1:0] rx_data_o,
    output logic                tx_byte_valid_o,
    output logic [DATASIZE-1:0] tx_byte_o,
    output logic                busy_o,
    output logic                stall_o,
    output logic                done_o,
    output logic                err_o,
    output logic [CNTSIZE-1:0]  bytes_left_o
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNTSIZE-1:0]  r_bytes_left;
    logic [CNTSIZE-1:0]  w_bytes_left_nxt;
    logic [DATASIZE-1:0] r_rx_data;
    logic [DATASIZE-1:0] w_rx_data_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic                r_push;
    logic                w_push_nxt;
    logic                r_stall;
    logic                w_stall_nxt;

    // State register
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        w_state_nxt      = r_state;
        w_bytes_left_nxt = r_bytes_left;
        w_rx_data_nxt    = r_rx_data;
        w_err_nxt        = r_err;
        w_push_nxt       = 1'b0;
        w_stall_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_bytes_left_nxt = byte_cnt_i;
                    w_err_nxt        = 1'b0;
                    if (byte_cnt_i == '0) begin
                        w_state_nxt = ST_DONE;
                    end else if (!rw_i) begin
                        w_state_nxt = ST_TX_LOAD;
                    end else begin
                        w_state_nxt = ST_RX_WAIT;
                    end
                end
            end
            ST_TX_LOAD: begin
                if (tx_empty_i) begin
                    w_stall_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_TX_SEND;
                end
            end
            ST_TX_SEND: begin
                // A NACK wins over a simultaneous accept: the byte is not popped.
                if (nack_i) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (tx_byte_ready_i) begin
                    w_state_nxt = ST_TX_POP;
                end
            end
            ST_TX_POP: begin
                if (r_bytes_left != '0) begin
                    w_bytes_left_nxt = r_bytes_left - CNTSIZE'(1);
                end
                w_state_nxt = (r_bytes_left <= CNTSIZE'(1)) ? ST_DONE : ST_TX_LOAD;
            end
            ST_RX_WAIT: begin
                if (rx_byte_valid_i) begin
                    w_rx_data_nxt = rx_byte_i;
                    w_state_nxt   = ST_RX_STORE;
                end
            end
            ST_RX_STORE: begin
                // The push pulse is registered, so it lands in the following cycle
                // while rx_data_o still holds the stored byte.
                if (rx_full_i) begin
                    w_stall_nxt = 1'b1;
                end else begin
                    w_push_nxt = 1'b1;
                    if (r_bytes_left != '0) begin
                        w_bytes_left_nxt = r_bytes_left - CNTSIZE'(1);
                    end
                    w_state_nxt = (r_bytes_left <= CNTSIZE'(1)) ? ST_DONE : ST_RX_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status
    always_ff @(posedge i2c_core_clk_i) begin
        if (i2c_core_rst_i) begin
            r_bytes_left <= '0;
            r_rx_data    <= '0;
            r_err        <= 1'b0;
            r_push       <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_bytes_left <= w_bytes_left_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_err        <= w_err_nxt;
            r_push       <= w_push_nxt;
            r_stall      <= w_stall_nxt;
        end
    end

    // Outputs: registers or pure state decodes; tx_byte_o passes the FWFT head through
    assign busy_o          = (r_state != ST_IDLE);
    assign tx_byte_valid_o = (r_state == ST_TX_SEND);
    assign tx_byte_o       = (r_state == ST_TX_SEND) ? tx_data_i : '0;
    assign r_tx_fifo_en_o  = (r_state == ST_TX_POP);
    assign done_o          = (r_state == ST_DONE);
    assign w_rx_fifo_en_o  = r_push;
    assign stall_o         = r_stall;
    assign err_o           = r_err;
    assign bytes_left_o    = r_bytes_left;
    assign rx_data_o       = r_rx_data;

endmodule

// File: tb/tb_i2c_fifo_sequencer.sv
// Scoreboard bench for i2c_fifo_sequencer: directed transfers with a TX-FIFO
// model, a bit-engine model and a monitor comparing against expected queues.
module tb_i2c_fifo_sequencer;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       rw_i;
    logic [7:0] byte_cnt_i;
    logic       tx_empty_i;
    logic [7:0] tx_data_i;
    logic       rx_full_i;
    logic       tx_byte_ready_i;
    logic       rx_byte_valid_i;
    logic [7:0] rx_byte_i;
    logic       nack_i;
    logic       r_tx_fifo_en_o;
    logic       w_rx_fifo_en_o;
    logic [7:0] rx_data_o;
    logic       tx_byte_valid_o;
    logic [7:0] tx_byte_o;
    logic       busy_o;
    logic       stall_o;
    logic       done_o;
    logic       err_o;
    logic [7:0] bytes_left_o;

    i2c_fifo_sequencer #(.DATASIZE(8), .CNTSIZE(8)) dut (
        .i2c_core_clk_i  (clk),
        .i2c_core_rst_i  (rst),
        .start_i         (start_i),
        .rw_i            (rw_i),
        .byte_cnt_i      (byte_cnt_i),
        .tx_empty_i      (tx_empty_i),
        .tx_data_i       (tx_data_i),
        .rx_full_i       (rx_full_i),
        .tx_byte_ready_i (tx_byte_ready_i),
        .rx_byte_valid_i (rx_byte_valid_i),
        .rx_byte_i       (rx_byte_i),
        .nack_i          (nack_i),
        .r_tx_fifo_en_o  (r_tx_fifo_en_o),
        .w_rx_fifo_en_o  (w_rx_fifo_en_o),
        .rx_data_o       (rx_data_o),
        .tx_byte_valid_o (tx_byte_valid_o),
        .tx_byte_o       (tx_byte_o),
        .busy_o          (busy_o),
        .stall_o         (stall_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .bytes_left_o    (bytes_left_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Monitor event counters (written only by the monitor)
    int n_pop = 0;
    int n_push = 0;
    int n_stall = 0;
    int n_done = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [8:0] exp_done[$];   // {err, bytes_left}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // TX-FIFO model: preloaded memory, read pointer owned by the pop process
    logic [7:0] tx_mem [0:15];
    logic [3:0] tx_wr;
    logic [3:0] tx_rd;
    logic       hold_empty;
    assign tx_empty_i = hold_empty || (tx_rd == tx_wr);
    assign tx_data_i  = tx_mem[tx_rd];

    initial tx_rd = 4'd0;
    always @(negedge clk) begin
        if (r_tx_fifo_en_o) tx_rd = tx_rd + 4'd1;
    end

    // Bit-engine model: accepts on the third valid cycle, or NACKs a chosen byte
    logic       nack_en;
    logic [7:0] nack_val;
    int         vcnt = 0;
    initial begin
        tx_byte_ready_i = 1'b0;
        nack_i          = 1'b0;
    end
    always @(negedge clk) begin
        if (tx_byte_valid_o) begin
            vcnt++;
            if (vcnt >= 3) begin
                if (nack_en && tx_byte_o == nack_val) begin
                    nack_i          = 1'b1;
                    tx_byte_ready_i = 1'b0;
                end else begin
                    nack_i          = 1'b0;
                    tx_byte_ready_i = 1'b1;
                end
            end
        end else begin
            vcnt            = 0;
            nack_i          = 1'b0;
            tx_byte_ready_i = 1'b0;
        end
    end

    // Monitor: compares every presented output event against the scoreboard
    always @(negedge clk) begin
        #1;
        if (tx_byte_valid_o && tx_byte_ready_i) begin
            if (exp_tx.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL tx_unexpected: got byte 0x%0h with nothing expected", tx_byte_o);
            end else begin
                chk("tx_byte", 32'(tx_byte_o), 32'(exp_tx.pop_front()));
            end
        end
        if (w_rx_fifo_en_o) begin
            if (exp_rx.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL rx_unexpected: got push of 0x%0h with nothing expected", rx_data_o);
            end else begin
                chk("rx_push_data", 32'(rx_data_o), 32'(exp_rx.pop_front()));
            end
        end
        if (done_o) begin
            if (exp_done.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL done_unexpected: got done_o with nothing expected");
            end else begin
                chk("done_err_bytes", 32'({err_o, bytes_left_o}), 32'(exp_done.pop_front()));
            end
        end
        if (r_tx_fifo_en_o || w_rx_fifo_en_o)
            chk("pop_push_exclusive", 32'({r_tx_fifo_en_o, w_rx_fifo_en_o} == 2'b11), 32'd0);
        if (r_tx_fifo_en_o) n_pop++;
        if (w_rx_fifo_en_o) n_push++;
        if (stall_o)        n_stall++;
        if (done_o)         n_done++;
    end

    task automatic start_xfer(input logic rw, input logic [7:0] cnt);
        @(negedge clk);
        start_i    = 1'b1;
        rw_i       = rw;
        byte_cnt_i = cnt;
        @(negedge clk);
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int snap);
        int cyc;
        cyc = 0;
        while (n_done <= snap && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (n_done <= snap) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", name, cyc);
        end
        @(negedge clk);
    endtask

    task automatic tx_load(input logic [7:0] b);
        tx_mem[tx_wr] = b;
        tx_wr = tx_wr + 4'd1;
    endtask

    int s_pop, s_push, s_stall, s_done;
    task automatic snap_counts();
        s_pop = n_pop; s_push = n_push; s_stall = n_stall; s_done = n_done;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
        tx_wr           = 4'd0;
        hold_empty      = 1'b0;
        nack_en         = 1'b0;
        nack_val        = 8'h00;
        rst             = 1'b1;
        start_i         = 1'b0;
        rw_i            = 1'b0;
        byte_cnt_i      = 8'd0;
        rx_full_i       = 1'b0;
        rx_byte_valid_i = 1'b0;
        rx_byte_i       = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({busy_o, stall_o, done_o, err_o, tx_byte_valid_o,
                                r_tx_fifo_en_o, w_rx_fifo_en_o}), 32'd0);
        chk("reset_bytes_left", 32'(bytes_left_o), 32'd0);
        chk("reset_rx_data", 32'(rx_data_o), 32'd0);
        chk("reset_tx_byte", 32'(tx_byte_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write 3 bytes; a stray start mid-transfer must be ignored
        tx_load(8'hA1); tx_load(8'hB2); tx_load(8'hC3);
        exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2); exp_tx.push_back(8'hC3);
        exp_done.push_back({1'b0, 8'd0});
        snap_counts();
        start_xfer(1'b0, 8'd3);
        chk("w3_busy", 32'(busy_o), 32'd1);
        chk("w3_bytes_left", 32'(bytes_left_o), 32'd3);
        @(negedge clk);
        start_i = 1'b1; rw_i = 1'b1; byte_cnt_i = 8'd9;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("w3", s_done);
        chk("w3_pops", 32'(n_pop - s_pop), 32'd3);
        chk("w3_dones", 32'(n_done - s_done), 32'd1);
        chk("w3_err", 32'(err_o), 32'd0);
        chk("w3_idle", 32'(busy_o), 32'd0);

        // Write 2 bytes with TX empty for 5 cycles after start
        tx_load(8'h11); tx_load(8'h22);
        exp_tx.push_back(8'h11); exp_tx.push_back(8'h22);
        exp_done.push_back({1'b0, 8'd0});
        snap_counts();
        hold_empty = 1'b1;
        start_xfer(1'b0, 8'd2);
        repeat (5) @(negedge clk);
        chk("w2_no_early_pop", 32'(n_pop - s_pop), 32'd0);
        hold_empty = 1'b0;
        wait_done("w2", s_done);
        chk("w2_stall_cycles", 32'(n_stall - s_stall), 32'd5);
        chk("w2_pops", 32'(n_pop - s_pop), 32'd2);

        // Read 2 bytes, RX full for 4 cycles on the first; stray valid in RX_STORE ignored
        exp_rx.push_back(8'h5A); exp_rx.push_back(8'h3C);
        exp_done.push_back({1'b0, 8'd0});
        snap_counts();
        start_xfer(1'b1, 8'd2);
        @(negedge clk);
        rx_byte_valid_i = 1'b1; rx_byte_i = 8'h5A; rx_full_i = 1'b1;
        @(negedge clk);
        rx_byte_valid_i = 1'b0;
        @(negedge clk);
        rx_byte_valid_i = 1'b1; rx_byte_i = 8'hEE;
        @(negedge clk);
        rx_byte_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("r2_push_delayed", 32'(n_push - s_push), 32'd0);
        rx_full_i = 1'b0;
        repeat (2) @(negedge clk);
        rx_byte_valid_i = 1'b1; rx_byte_i = 8'h3C;
        @(negedge clk);
        rx_byte_valid_i = 1'b0;
        wait_done("r2", s_done);
        chk("r2_stall_cycles", 32'(n_stall - s_stall), 32'd4);
        chk("r2_pushes", 32'(n_push - s_push), 32'd2);
        chk("r2_dones", 32'(n_done - s_done), 32'd1);

        // Write 4 bytes with NACK on byte 2
        tx_load(8'hD1); tx_load(8'hD2); tx_load(8'hD3); tx_load(8'hD4);
        exp_tx.push_back(8'hD1);
        exp_done.push_back({1'b1, 8'd3});
        nack_en = 1'b1; nack_val = 8'hD2;
        snap_counts();
        start_xfer(1'b0, 8'd4);
        wait_done("nack", s_done);
        nack_en = 1'b0;
        chk("nack_pops", 32'(n_pop - s_pop), 32'd1);
        chk("nack_err_sticky", 32'(err_o), 32'd1);
        chk("nack_bytes_left", 32'(bytes_left_o), 32'd3);

        // Zero-length transfer: done next cycle, err cleared, no FIFO traffic
        exp_done.push_back({1'b0, 8'd0});
        snap_counts();
        start_xfer(1'b0, 8'd0);
        chk("zero_done_next", 32'(done_o), 32'd1);
        wait_done("zero", s_done);
        chk("zero_no_traffic", 32'((n_pop - s_pop) + (n_push - s_push)), 32'd0);

        // Reset while stalled in RX_STORE, with RX becoming free in the same cycle
        snap_counts();
        start_xfer(1'b1, 8'd1);
        @(negedge clk);
        rx_byte_valid_i = 1'b1; rx_byte_i = 8'h77; rx_full_i = 1'b1;
        @(negedge clk);
        rx_byte_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_rx_data", 32'(rx_data_o), 32'h77);
        rst = 1'b1; rx_full_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_flags", 32'({busy_o, stall_o, done_o, err_o, tx_byte_valid_o,
                                  r_tx_fifo_en_o, w_rx_fifo_en_o}), 32'd0);
        chk("rst_mid_bytes_rx", 32'({bytes_left_o, rx_data_o}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_push_done", 32'((n_push - s_push) + (n_done - s_done)), 32'd0);

        chk("sb_tx_drained", 32'(exp_tx.size()), 32'd0);
        chk("sb_rx_drained", 32'(exp_rx.size()), 32'd0);
        chk("sb_done_drained", 32'(exp_done.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
